// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: streams operands LSB-first through one full_adder cell.
// Optional signed-overflow output oOvf is built when SERIAL_ADD_OVF_EN is defined.

module full_adder (
  input  logic iA,
  input  logic iB,
  input  logic iCin,
  output logic oSum,
  output logic oCout
);

  assign oSum  = iA ^ iB ^ iCin;
  assign oCout = (iA & iB) | (iA & iCin) | (iB & iCin);

endmodule

// Handshake: iStart is a request accepted only on an edge where oBusy is low
// (IDLE); while oBusy is high, requests are dropped, not queued. oDone pulses
// for exactly one cycle when oSum/oCout carry the new result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCin,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oSum,
  output logic             oCout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             oOvf,
`endif
  output logic [1:0]       oState
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [WIDTH-1:0] rA;
  logic [WIDTH-1:0] rB;
  logic [WIDTH-1:0] rPart;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             faSum;
  logic             faCout;
  logic             lastBit;
  logic [WIDTH:0]   partExt;
  logic [WIDTH-1:0] partNext;

  full_adder uCell (
    .iA   (rA[0]),
    .iB   (rB[0]),
    .iCin (carry),
    .oSum (faSum),
    .oCout(faCout)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign partExt  = {faSum, rPart};
  assign partNext = partExt[WIDTH:1];
  assign lastBit  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iStart) stateNext = RUN;
      RUN:     if (lastBit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      rA    <= '0;
      rB    <= '0;
      rPart <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      oSum  <= '0;
      oCout <= 1'b0;
      oDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            rA    <= iA;
            rB    <= iB;
            carry <= iCin;
            rPart <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          rA    <= rA >> 1;
          rB    <= rB >> 1;
          rPart <= partNext;
          carry <= faCout;
          cnt   <= cnt + CW'(1);
          if (lastBit) begin
            oSum  <= partNext;
            oCout <= faCout;
            oDone <= 1'b1;
          end
        end
        DONE: begin
          oDone <= 1'b0;
        end
        default: begin
          oDone <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // On the final bit, carry holds the carry into the MSB and faCout the carry out.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oOvf <= 1'b0;
    end else if (state == RUN && lastBit) begin
      oOvf <= carry ^ faCout;
    end
  end
`endif

  assign oBusy  = (state != IDLE);
  assign oState = state;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial multi-bit adder that drives one full_adder cell.
- Loads two WIDTH-bit operands, then streams them LSB-first into the full_adder (iA, iB, iCin), one bit per clock.
- Feeds the cell's oCout back through a carry flip-flop, and assembles the oSum bits into a WIDTH-bit result.
- Sits directly upstream and downstream of full_adder: the only thing that sources its inputs and consumes its outputs.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
iClk  input  1  clock; all state changes on rising edge
iRst_n  input  1  synchronous active-low reset, sampled on rising edge of iClk
iStart  input  1  request to start an addition; sampled only in IDLE
iA  input  WIDTH  operand A, captured on the accepting edge
iB  input  WIDTH  operand B, captured on the accepting edge
iCin  input  1  carry-in, captured on the accepting edge
oBusy  output  1  high while in RUN or DONE
oDone  output  1  one-cycle completion pulse
oSum  output  WIDTH  result register, held between operations
oCout  output  1  final carry-out, held between operations

Behaviour:
- Interface: one clock, iClk. Reset iRst_n is synchronous and active-low.
- Reset: iRst_n low at an edge forces the following, overriding all else:
  - state IDLE, oBusy=0, oDone=0;
  - oSum=0, oCout=0;
  - operand shift registers, carry FF and bit counter all 0.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - iStart=1 at edge E: load rA<=iA, rB<=iB, carry<=iCin, cnt<=0; go to RUN.
  - iStart=0: stay in IDLE.
- RUN, each edge:
  - full_adder inputs are (rA[0], rB[0], carry).
  - Sum bit shifts into the MSB of the partial-sum register (shift right); rA and rB shift right.
  - carry<=cout, cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: copy the completed sum into oSum, cout into oCout, set oDone<=1, go to DONE.
- DONE:
  - Lasts exactly one cycle; oDone=1 during it.
  - Next edge: oDone<=0, return to IDLE.
- Latency: start accepted at edge E gives oSum/oCout updated and oDone high at edge E+WIDTH, with oDone low again at E+WIDTH+1.
- Back-to-back: the minimum start-to-start interval is WIDTH+2 cycles. Holding iStart=1 continuously restarts in each IDLE cycle.
- iStart in RUN or DONE: ignored, never queued. iA/iB/iCin changes after the accepting edge have no effect.
- oSum/oCout change only at the completion edge or reset; they stay stable during RUN.
- Arithmetic: {oCout,oSum} = iA + iB + iCin, unsigned modulo 2^(WIDTH+1), exact.
- WIDTH=1: RUN lasts one cycle; cnt compares to 0.
- cnt is sized ceil(log2(WIDTH)), minimum 1 bit.
- Reset mid-RUN: operation aborted; no oDone; oSum/oCout=0.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output oOvf (1 bit), the signed two's-complement overflow flag = (carry into the MSB) XOR (carry out of the MSB).
  - Carry into the MSB is the carry FF value used on the final RUN edge.
  - oOvf updates at the completion edge alongside oSum, holds between operations, and resets to 0.
- Undefined: no oOvf port and no related logic. All other behaviour is identical.

Test Plan:
- WIDTH=8: iA=0x5A, iB=0x3C, iCin=0, pulse iStart -> oDone high exactly 8 cycles after the accepting edge; oSum=0x96, oCout=0; oBusy high for 9 cycles.
- iA=0xFF, iB=0x01, iCin=0 -> oSum=0x00, oCout=1. Then iA=0xFF, iB=0xFF, iCin=1 -> oSum=0xFF, oCout=1.
- Start 0x12+0x34, pulse iStart again with iA=0xFF at cycle 3 of RUN -> second pulse ignored; oSum=0x46, oCout=0; a single oDone pulse.
- Start 0xAA+0x55, drive iRst_n=0 at cycle 4 of RUN -> next cycle: IDLE, oBusy=0, oSum=0, oCout=0; no oDone ever asserted for that operation.
- iStart held high for 30 cycles with iA=0x01, iB=0x01 -> oDone pulses every 10 cycles; oSum=0x02 each time; oSum stable between pulses.
- With SERIAL_ADD_OVF_EN: 0x7F+0x01 -> oSum=0x80, oOvf=1. Then 0x80+0x80 -> oSum=0x00, oCout=1, oOvf=1. Then 0x40+0x20 -> oOvf=0.
